// File: rtl/fsk_frame_rx_if.sv
// rtl/fsk_frame_rx_if.sv - receive-word stream handshake between the FSK receiver and its consumer
// Signals: rx_data (FIFO head word), rx_valid (head present), rx_ready (consumer takes head).
// Modports: master = receiver side, slave = consumer side.
`timescale 1ns/1ps
interface fsk_frame_rx_if #(
    parameter int DATA_W = 12
) ();
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/fsk_frame_rx.sv
// rtl/fsk_frame_rx.sv - oversampling FSK serial frame receiver with output FIFO and error reporting
// Ports: sysclk, rst_n (async active-low), signal_in (serial line, idle high),
//   rx (master modport: rx_data/rx_valid/rx_ready), busy, frame_err/parity_err/overflow
//   (one-cycle pulses), err_cnt (saturating event count), fifo_count (FIFO occupancy).
// Optional feature: define FSK_RX_PARITY_EN to add an even-parity bit after the data bits.
`timescale 1ns/1ps
module fsk_frame_rx #(
    parameter int DATA_W     = 12,
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        sysclk,
    input  logic                        rst_n,
    input  logic                        signal_in,
    fsk_frame_rx_if.master              rx,
    output logic                        busy,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overflow,
    output logic [7:0]                  err_cnt,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int CW   = $clog2(OVS);
    localparam int BW   = $clog2(DATA_W + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t            state, state_next;
    logic              s_meta, s, s_d, fall;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              mid_half, mid_full;
    logic              cnt_clr, frame_start, shift_en, good_frame, ferr_set, ovf_set, evt;
    logic              push, pop, full;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
`ifdef FSK_RX_PARITY_EN
    logic              perr_set, par_bad;
`endif

    // Two synchroniser flops plus one history flop for falling-edge detection.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta <= 1'b1;
            s      <= 1'b1;
            s_d    <= 1'b1;
        end else begin
            s_meta <= signal_in;
            s      <= s_meta;
            s_d    <= s;
        end
    end
    assign fall = s_d & ~s;

    // cnt is cleared on every sampling event, so START samples after OVS/2
    // cycles and every later state samples one full bit period later.
    assign mid_half = (cnt == CW'(OVS / 2 - 1));
    assign mid_full = (cnt == CW'(OVS - 1));

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        cnt_clr     = 1'b0;
        frame_start = 1'b0;
        shift_en    = 1'b0;
        good_frame  = 1'b0;
        ferr_set    = 1'b0;
`ifdef FSK_RX_PARITY_EN
        perr_set    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (fall) begin
                    state_next  = S_START;
                    cnt_clr     = 1'b1;
                    frame_start = 1'b1;
                end
            end
            S_START: begin
                if (mid_half) begin
                    cnt_clr    = 1'b1;
                    state_next = s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (mid_full) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == BW'(DATA_W - 1)) begin
`ifdef FSK_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef FSK_RX_PARITY_EN
            S_PARITY: begin
                if (mid_full) begin
                    cnt_clr    = 1'b1;
                    state_next = S_STOP;
                    perr_set   = ^{shreg, s};
                end
            end
`endif
            S_STOP: begin
                if (mid_full) begin
                    cnt_clr    = 1'b1;
                    state_next = S_IDLE;
                    // A parity failure already reported the frame; the stop bit is then ignored.
`ifdef FSK_RX_PARITY_EN
                    if (!par_bad) begin
`else
                    begin
`endif
                        if (!s) ferr_set   = 1'b1;
                        else    good_frame = 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    // A pop in the same cycle frees the slot, so a full FIFO only overflows without one.
    assign full    = (fifo_count == CNTW'(FIFO_DEPTH));
    assign pop     = rx.rx_valid & rx.rx_ready;
    assign push    = good_frame & (~full | pop);
    assign ovf_set = good_frame & full & ~pop;
`ifdef FSK_RX_PARITY_EN
    assign evt     = ferr_set | ovf_set | perr_set;
`else
    assign evt     = ferr_set | ovf_set;
`endif

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            cnt       <= cnt_clr ? '0 : cnt + 1'b1;
            frame_err <= ferr_set;
            overflow  <= ovf_set;
            if (frame_start) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= (shreg << 1) | DATA_W'(s);
            end
            if (evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
        end
    end

`ifdef FSK_RX_PARITY_EN
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= perr_set;
            if (frame_start)   par_bad <= 1'b0;
            else if (perr_set) par_bad <= 1'b1;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // Storage has no reset; rx_data is masked while the FIFO is empty.
    always_ff @(posedge sysclk) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign rx.rx_valid = (fifo_count != '0);
    assign rx.rx_data  = rx.rx_valid ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_fsk_frame_rx.sv
// tb/tb_fsk_frame_rx.sv - self-checking bench for fsk_frame_rx
`timescale 1ns/1ps
module tb_fsk_frame_rx;
    localparam int DATA_W     = 12;
    localparam int OVS        = 16;
    localparam int FIFO_DEPTH = 4;
`ifdef FSK_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // First low drive -> 2 sync flops -> edge seen one cycle later (t0), sample at t0+OVS/2, then whole bits.
    localparam int T_PAR  = 3 + OVS / 2 + (DATA_W + 1) * OVS;
    localparam int T_STOP = 3 + OVS / 2 + (DATA_W + PAR_BITS + 1) * OVS;

    logic                        sysclk;
    logic                        rst_n;
    logic                        signal_in;
    logic                        busy, frame_err, parity_err, overflow;
    logic [7:0]                  err_cnt;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    fsk_frame_rx_if #(.DATA_W(DATA_W)) rx_if ();

    fsk_frame_rx #(.DATA_W(DATA_W), .OVS(OVS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .signal_in  (signal_in),
        .rx         (rx_if),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overflow   (overflow),
        .err_cnt    (err_cnt),
        .fifo_count (fifo_count)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Observations made away from the clock edge.
    logic [DATA_W-1:0] got[$];
    int ferr_seen = 0, ovf_seen = 0, perr_seen = 0, stab_err = 0;
    int rise_cyc = -1, ferr_cyc = -1, perr_cyc = -1;
    logic prev_valid = 1'b0, prev_ready = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    always @(negedge sysclk) begin
        if (rx_if.rx_valid && rx_if.rx_ready) got.push_back(rx_if.rx_data);
        if (rx_if.rx_valid && !prev_valid) rise_cyc = cyc;
        if (frame_err)  begin ferr_seen++; ferr_cyc = cyc; end
        if (parity_err) begin perr_seen++; perr_cyc = cyc; end
        if (overflow)   ovf_seen++;
        if (prev_valid && !prev_ready && rx_if.rx_valid && rx_if.rx_data != prev_data) stab_err++;
        prev_valid = rx_if.rx_valid;
        prev_ready = rx_if.rx_ready;
        prev_data  = rx_if.rx_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    int last_start;
`ifdef FSK_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    task automatic idle(input int n);
        signal_in = 1'b1;
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        signal_in = b;
        repeat (OVS) @(posedge sysclk);
        #1;
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] w, input logic stop_b);
        last_start = cyc;
        drive_bit(1'b0);
        for (int i = DATA_W - 1; i >= 0; i--) drive_bit(w[i]);
`ifdef FSK_RX_PARITY_EN
        drive_bit((^w) ^ par_flip);
`endif
        drive_bit(stop_b);
        signal_in = 1'b1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        signal_in      = 1'b1;
        rx_if.rx_ready = 1'b0;
        repeat (2) @(posedge sysclk);
        #1;
        rst_n = 1'b1;
        idle(4);
    endtask

    task automatic drain(input int n);
        rx_if.rx_ready = 1'b1;
        repeat (n + 1) @(posedge sysclk);
        #1;
        rx_if.rx_ready = 1'b0;
    endtask

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              stop_b;
        int                exp_count;
        int                exp_err;
        int                exp_ferr;
        int                exp_ovf;
    } vec_t;

    vec_t              vecs[6];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] w;
    logic              sb;
    int                base, f0, o0, p0, nerr;
    bit                rnd_done;

    initial begin
        rst_n          = 1'b0;
        signal_in      = 1'b1;
        rx_if.rx_ready = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        check("reset rx_valid",   32'(rx_if.rx_valid), 0);
        check("reset rx_data",    32'(rx_if.rx_data), 0);
        check("reset busy",       32'(busy), 0);
        check("reset frame_err",  32'(frame_err), 0);
        check("reset parity_err", 32'(parity_err), 0);
        check("reset overflow",   32'(overflow), 0);
        check("reset err_cnt",    32'(err_cnt), 0);
        check("reset fifo_count", 32'(fifo_count), 0);
        rst_n = 1'b1;
        idle(5);

        // Basic frame and rx_valid latency.
        send_frame(12'hD94, 1'b1);
        check("t1 rx_valid rise cycle", rise_cyc, last_start + T_STOP);
        check("t1 rx_data",    32'(rx_if.rx_data), 32'hD94);
        check("t1 fifo_count", 32'(fifo_count), 1);
        check("t1 err_cnt",    32'(err_cnt), 0);
        base = got.size();
        drain(1);
        check("t1 popped count", got.size() - base, 1);
        if (got.size() > base) check("t1 popped word", 32'(got[base]), 32'hD94);

        // 3-cycle low glitch: START entered then abandoned at mid-bit.
        f0 = ferr_seen; o0 = ovf_seen; p0 = perr_seen;
        signal_in = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        signal_in = 1'b1;
        repeat (2) @(posedge sysclk);
        #1;
        check("glitch busy during start", 32'(busy), 1);
        repeat (10) @(posedge sysclk);
        #1;
        check("glitch busy after abort", 32'(busy), 0);
        check("glitch fifo_count", 32'(fifo_count), 0);
        check("glitch pulses", ferr_seen - f0 + ovf_seen - o0 + perr_seen - p0, 0);
        idle(OVS);

        // Stop bit 0.
        f0 = ferr_seen;
        send_frame(12'h123, 1'b0);
        check("ferr pulse count", ferr_seen - f0, 1);
        check("ferr pulse cycle", ferr_cyc, last_start + T_STOP);
        check("ferr fifo_count", 32'(fifo_count), 0);
        check("ferr err_cnt", 32'(err_cnt), 1);

        // Table: back-to-back frames with no consumer.
        vecs[0] = '{12'h001, 1'b1, 1, 0, 0, 0};
        vecs[1] = '{12'h002, 1'b1, 2, 0, 0, 0};
        vecs[2] = '{12'h003, 1'b1, 3, 0, 0, 0};
        vecs[3] = '{12'h004, 1'b1, 4, 0, 0, 0};
        vecs[4] = '{12'h005, 1'b1, 4, 1, 0, 1};
        vecs[5] = '{12'hFFF, 1'b0, 4, 2, 1, 0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            f0 = ferr_seen; o0 = ovf_seen;
            send_frame(vecs[i].data, vecs[i].stop_b);
            check($sformatf("vec%0d fifo_count", i), 32'(fifo_count), vecs[i].exp_count);
            check($sformatf("vec%0d err_cnt", i), 32'(err_cnt), vecs[i].exp_err);
            check($sformatf("vec%0d frame_err", i), ferr_seen - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d overflow", i), ovf_seen - o0, vecs[i].exp_ovf);
            check($sformatf("vec%0d head", i), 32'(rx_if.rx_data), 32'h001);
        end
        base = got.size();
        drain(4);
        check("table drain count", got.size() - base, 4);
        for (int i = 0; i < 4 && base + i < got.size(); i++)
            check($sformatf("table drain word%0d", i), 32'(got[base + i]), 32'(i + 1));
        check("table drain rx_valid", 32'(rx_if.rx_valid), 0);

        // Full FIFO with a pop in the cycle of the 5th stop sample.
        base = got.size();
        for (int i = 1; i <= 4; i++) send_frame(DATA_W'(i), 1'b1);
        check("fullpop fifo_count before", 32'(fifo_count), 4);
        o0 = ovf_seen;
        fork
            send_frame(12'h005, 1'b1);
            begin
                repeat (T_STOP - 1) @(posedge sysclk);
                #1;
                rx_if.rx_ready = 1'b1;
                @(posedge sysclk);
                #1;
                rx_if.rx_ready = 1'b0;
            end
        join
        check("fullpop overflow", ovf_seen - o0, 0);
        check("fullpop fifo_count", 32'(fifo_count), 4);
        drain(4);
        check("fullpop words", got.size() - base, 5);
        for (int i = 0; i < 5 && base + i < got.size(); i++)
            check($sformatf("fullpop word%0d", i), 32'(got[base + i]), 32'(i + 1));

        // Reset in the middle of a frame's data bits, with one word already stored.
        send_frame(12'h777, 1'b1);
        drive_bit(1'b0);
        w = 12'hABC;
        for (int i = DATA_W - 1; i >= 6; i--) drive_bit(w[i]);
        rst_n = 1'b0;
        #2;
        check("midrst busy",       32'(busy), 0);
        check("midrst fifo_count", 32'(fifo_count), 0);
        check("midrst rx_valid",   32'(rx_if.rx_valid), 0);
        check("midrst rx_data",    32'(rx_if.rx_data), 0);
        check("midrst err_cnt",    32'(err_cnt), 0);
        signal_in = 1'b1;
        repeat (2) @(posedge sysclk);
        #1;
        rst_n = 1'b1;
        idle(2 * OVS);
        send_frame(12'h555, 1'b1);
        check("postrst fifo_count", 32'(fifo_count), 1);
        check("postrst head", 32'(rx_if.rx_data), 32'h555);
        drain(1);
`ifdef FSK_RX_PARITY_EN
        p0 = perr_seen; f0 = ferr_seen;
        par_flip = 1'b1;
        send_frame(12'h555, 1'b1);
        check("parity pulse count", perr_seen - p0, 1);
        check("parity pulse cycle", perr_cyc, last_start + T_PAR);
        check("parity no write", 32'(fifo_count), 0);
        send_frame(12'h00F, 1'b0);
        par_flip = 1'b0;
        check("parity+stop0 parity_err", perr_seen - p0, 2);
        check("parity+stop0 frame_err", ferr_seen - f0, 0);
        check("parity err_cnt", 32'(err_cnt), 2);
`endif

        // Randomized frames against a queue model; the consumer is randomly ready.
        do_reset();
        base = got.size(); f0 = ferr_seen; o0 = ovf_seen; nerr = 0;
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    w  = DATA_W'($urandom);
                    sb = ($urandom_range(0, 9) != 0);
                    if ($urandom_range(0, 3) == 0) begin
                        signal_in = 1'b0;
                        repeat ($urandom_range(1, 5)) @(posedge sysclk);
                        #1;
                        idle(OVS);
                    end
                    idle($urandom_range(0, 20));
                    send_frame(w, sb);
                    if (sb) exp_q.push_back(w);
                    else    nerr++;
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge sysclk);
                    #1;
                    rx_if.rx_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        drain(FIFO_DEPTH + 2);
        check("rand word count", got.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < got.size(); i++)
            check($sformatf("rand word%0d", i), 32'(got[base + i]), 32'(exp_q[i]));
        check("rand frame_err count", ferr_seen - f0, nerr);
        check("rand overflow count", ovf_seen - o0, 0);
        check("rand err_cnt", 32'(err_cnt), nerr);
        check("rx_data stable while stalled", stab_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
